univ_shift_reg_n: RTL and testbench
===================================

# univ_shift_reg_n

Parametrised universal shift register with WIDTH-bit storage and eight operating modes: hold, logical shift both ways, parallel load, rotate both ways, arithmetic shift and clear. It adds a counted burst engine: a start/busy/done handshake runs a chosen shift or rotate mode for a programmed number of steps without per-cycle control. It is the successor to the fixed 4-bit mux/flip-flop shifter and sits in datapath blocks as a serialiser/deserialiser, barrel-shift helper and bit-test shifter.

## Interface
Parameters:
- WIDTH, 8, register width; must be >= 2.
- CNT_W, 4, width of burst_len; maximum burst is 2^CNT_W-1 steps.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  step enable; gates every register update except clear-by-reset.
- mode  in  3  operation select; see Operation.
- sin_lo  in  1  serial input entering bit 0 on a shift up.
- sin_hi  in  1  serial input entering bit WIDTH-1 on a shift down.
- pin  in  WIDTH  parallel load data.
- start  in  1  burst request; sampled in IDLE only.
- burst_len  in  CNT_W  number of burst steps; sampled with start.
- q  out  WIDTH  register contents.
- sout_lo  out  1  equals q[0] (combinational).
- sout_hi  out  1  equals q[WIDTH-1] (combinational).
- busy  out  1  high while a burst is running (registered).
- done  out  1  one-cycle pulse after the last burst step (registered).

## Operation
Mode encoding. Each mode applies per edge when en=1 and the block is in IDLE with no accepted start:
- 000 hold: q unchanged.
- 001 shift up: q <= {q[WIDTH-2:0], sin_lo}.
- 010 shift down: q <= {sin_hi, q[WIDTH-1:1]}.
- 011 load: q <= pin.
- 100 rotate up: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 101 rotate down: q <= {q[0], q[WIDTH-1:1]}.
- 110 arithmetic shift down: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
- 111 clear: q <= 0.
- en=0 in IDLE: q holds regardless of mode.

FSM states: IDLE and RUN.
- **Start acceptance.** In IDLE, start=1 is accepted when both hold: mode is in {001,010,100,101,110} and burst_len != 0. On acceptance:
  - bmode <= mode; cnt <= burst_len; state <= RUN.
  - q holds in the acceptance cycle, even if en=1.
- **Start not accepted.** If start=1 with burst_len=0 or a non-shift mode, start is ignored. The cycle behaves as a normal mode cycle and done is not pulsed.
- **RUN.** Each edge with en=1 applies one step of bmode and decrements cnt. en=0 pauses: q and cnt hold and busy stays 1.
- **Inputs during RUN.** mode, start, pin and burst_len are ignored. sin_lo and sin_hi are still used live for bmode 001 and 010.
- **Leaving RUN.** On the step where cnt==1: state <= IDLE, busy <= 0, done <= 1.
- **done.** done is high for exactly one cycle; it is cleared on the next edge unconditionally.
- **Back-to-back bursts.** A start presented in the cycle where done=1 is accepted normally.

## Timing
- **Reset.** After rst is sampled high: q=0, busy=0, done=0, cnt=0, state=IDLE.
  - rst overrides en, start and an in-progress burst.
  - A burst aborted by reset produces no done pulse.
- **Normal-mode latency.** One edge from mode/en/inputs to q.
- **Burst of N steps with en held high:**
  - start accepted at edge k.
  - busy=1 after edge k.
  - Steps occur at edges k+1 … k+N.
  - busy=0 and done=1 after edge k+N.
  - done=0 after edge k+N+1.
  - Total occupancy is N+1 cycles.
- **Paused bursts.** Each en=0 cycle in RUN extends the burst by one cycle.
- **Serial outputs.** sout_lo and sout_hi track q with no added delay.

## Test plan
- **Reset and load.** Assert rst for 2 cycles with mode=011 and pin=8'hFF -> q=00, busy=0, done=0. Release rst, load 8'hA5 -> q=A5 after 1 edge.
- **Serial shift up (WIDTH=4).** Apply mode=001 with sin_lo sequence 1,0,0,1 -> q = 1, 2, 4, 9; sout_hi=1 after the 4th edge.
- **Rotate and arithmetic shift.** Load 8'hA5, then mode=101 -> D2. Load 8'h90, then mode=110 twice -> C8, then E4. en=0 for one cycle in between -> q holds.
- **Burst rotate.** Load 8'h01, then start with mode=100 and burst_len=3:
  - busy high for exactly 3 cycles after acceptance; q goes 02, 04, 08.
  - done pulses once, concurrent with busy falling.
  - mode changes applied during RUN have no effect.
- **Burst edge cases:**
  - en=0 for 2 cycles mid-burst -> busy lasts 5 cycles; final q still 08.
  - start with burst_len=0, mode=100 -> one plain rotate, busy never rises, no done.
  - start with mode=011 -> a plain load occurs.
- **Reset mid-burst and back-to-back.**
  - rst asserted on the 2nd RUN cycle -> q=00, busy=0 next edge, no done.
  - A new start issued in the done cycle is accepted immediately.

Source files
------------

// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: parametrised universal shift register with eight per-edge
// modes (hold, shift up/down, load, rotate up/down, arithmetic shift, clear)
// plus a counted burst engine that repeats one shift/rotate mode for a
// programmed number of enabled steps behind a start/busy/done handshake.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_lo,
    input  logic             sin_hi,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_lo,
    output logic             sout_hi,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHUP  = 3'b001;
    localparam logic [2:0] M_SHDN  = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROTUP = 3'b100;
    localparam logic [2:0] M_ROTDN = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLR   = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bmode_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       sel_mode;
    logic [WIDTH-1:0] data_d;
    logic             shift_mode;
    logic             start_ok;

    // In RUN the latched burst mode drives the datapath; live mode is ignored.
    assign sel_mode = (state_q == RUN) ? bmode_q : mode;

    // Only shift/rotate modes may be bursted; load, hold and clear cannot.
    always_comb begin
        shift_mode = 1'b0;
        case (mode)
            M_SHUP, M_SHDN, M_ROTUP, M_ROTDN, M_ASR: shift_mode = 1'b1;
            default:                                shift_mode = 1'b0;
        endcase
    end

    assign start_ok = start && shift_mode && (burst_len != '0);

    // Next register value for one step of the selected mode.
    always_comb begin
        data_d = data_q;
        case (sel_mode)
            M_HOLD:  data_d = data_q;
            M_SHUP:  data_d = {data_q[WIDTH-2:0], sin_lo};
            M_SHDN:  data_d = {sin_hi, data_q[WIDTH-1:1]};
            M_LOAD:  data_d = pin;
            M_ROTUP: data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            M_ROTDN: data_d = {data_q[0], data_q[WIDTH-1:1]};
            M_ASR:   data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            M_CLR:   data_d = '0;
            default: data_d = data_q;
        endcase
    end

    // Burst FSM and register update; busy/done are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            bmode_q <= M_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        // Acceptance cycle: q holds even with en high.
                        bmode_q <= mode;
                        cnt_q   <= burst_len;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else if (en) begin
                        data_q <= data_d;
                    end
                end
                RUN: begin
                    if (en) begin
                        data_q <= data_d;
                        cnt_q  <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q       = data_q;
    assign sout_lo = data_q[0];
    assign sout_hi = data_q[WIDTH-1];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n (WIDTH=8, CNT_W=4). Each driven cycle
// pushes the reference model's expected outputs into a scoreboard queue,
// which is popped and compared one time unit after the following clock edge.
module tb_univ_shift_reg_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       sin_lo = 1'b0;
    logic       sin_hi = 1'b0;
    logic [7:0] pin = 8'h00;
    logic       start = 1'b0;
    logic [3:0] burst_len = 4'd0;
    logic [7:0] q;
    logic       sout_lo, sout_hi, busy, done;

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    int done_cnt;

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [7:0] m_q = 8'h00;
    logic       m_run = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [3:0] m_cnt = 4'd0;
    logic [2:0] m_bmode = 3'b000;

    univ_shift_reg_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sin_lo(sin_lo), .sin_hi(sin_hi), .pin(pin),
        .start(start), .burst_len(burst_len),
        .q(q), .sout_lo(sout_lo), .sout_hi(sout_hi),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_step(input logic [2:0] m, input logic [7:0] v,
                                            input logic sl, input logic sh, input logic [7:0] p);
        case (m)
            3'd1:    return {v[6:0], sl};
            3'd2:    return {sh, v[7:1]};
            3'd3:    return p;
            3'd4:    return {v[6:0], v[7]};
            3'd5:    return {v[0], v[7:1]};
            3'd6:    return {v[7], v[7:1]};
            3'd7:    return 8'h00;
            default: return v;
        endcase
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One transaction: drive inputs, predict, clock, pop and compare.
    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic sl, input logic sh, input logic [7:0] p,
                       input logic st, input logic [3:0] bl);
        exp_t x;
        logic accept;
        @(negedge clk);
        rst = r; en = e; mode = m; sin_lo = sl; sin_hi = sh;
        pin = p; start = st; burst_len = bl;
        m_done = 1'b0;
        if (r) begin
            m_q = 8'h00; m_run = 1'b0; m_busy = 1'b0; m_cnt = 4'd0;
        end else if (!m_run) begin
            accept = st && (m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5 || m == 3'd6)
                     && (bl != 4'd0);
            if (accept) begin
                m_bmode = m; m_cnt = bl; m_run = 1'b1; m_busy = 1'b1;
            end else if (e) begin
                m_q = ref_step(m, m_q, sl, sh, p);
            end
        end else if (e) begin
            m_q = ref_step(m_bmode, m_q, sl, sh, p);
            if (m_cnt == 4'd1) begin
                m_run = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end
            m_cnt = m_cnt - 4'd1;
        end
        x.q = m_q; x.busy = m_busy; x.done = m_done;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        $display("t=%0t rst=%b en=%b mode=%0d st=%b len=%0d -> q=%h busy=%b done=%b",
                 $time, r, e, m, st, bl, q, busy, done);
        chk8("q", q, x.q);
        chk1("busy", busy, x.busy);
        chk1("done", done, x.done);
        chk1("sout_lo", sout_lo, x.q[0]);
        chk1("sout_hi", sout_hi, x.q[7]);
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    endtask

    initial begin
        // Reset for two cycles with a load presented: reset wins.
        cyc(1, 1, 3'd3, 0, 0, 8'hFF, 0, 0);
        cyc(1, 1, 3'd3, 0, 0, 8'hFF, 0, 0);
        chk8("reset_q", q, 8'h00);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        cyc(0, 1, 3'd3, 0, 0, 8'hA5, 0, 0);
        chk8("load_a5", q, 8'hA5);

        // Serial shift up: clear, then sin_lo 1,0,0,1, then four more zeros.
        cyc(0, 1, 3'd7, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 3'd1, 1, 0, 8'h00, 0, 0);
        cyc(0, 1, 3'd1, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 3'd1, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 3'd1, 1, 0, 8'h00, 0, 0);
        chk8("shup_09", q, 8'h09);
        for (int i = 0; i < 4; i++) cyc(0, 1, 3'd1, 0, 0, 8'h00, 0, 0);
        chk8("shup_90", q, 8'h90);
        chk1("shup_sout_hi", sout_hi, 1'b1);
        cyc(0, 1, 3'd2, 0, 1, 8'h00, 0, 0);
        chk8("shdn_c8", q, 8'hC8);

        // Rotate down and arithmetic shift with an en=0 gap.
        cyc(0, 1, 3'd3, 0, 0, 8'hA5, 0, 0);
        cyc(0, 1, 3'd5, 0, 0, 8'h00, 0, 0);
        chk8("rotdn_d2", q, 8'hD2);
        cyc(0, 1, 3'd3, 0, 0, 8'h90, 0, 0);
        cyc(0, 1, 3'd6, 0, 0, 8'h00, 0, 0);
        chk8("asr_c8", q, 8'hC8);
        cyc(0, 0, 3'd6, 0, 0, 8'h00, 0, 0);
        chk8("en0_hold", q, 8'hC8);
        cyc(0, 1, 3'd6, 0, 0, 8'h00, 0, 0);
        chk8("asr_e4", q, 8'hE4);

        // Burst rotate up by 3; live mode/pin/start changes during RUN.
        cyc(0, 1, 3'd3, 0, 0, 8'h01, 0, 0);
        busy_cnt = 0; done_cnt = 0;
        cyc(0, 1, 3'd4, 0, 0, 8'h00, 1, 4'd3);
        chk8("burst_accept_hold", q, 8'h01);
        cyc(0, 1, 3'd3, 0, 0, 8'hFF, 1, 4'd9);
        chk8("burst_step1", q, 8'h02);
        cyc(0, 1, 3'd7, 0, 0, 8'hFF, 0, 0);
        chk8("burst_step2", q, 8'h04);
        cyc(0, 1, 3'd5, 0, 0, 8'hFF, 0, 0);
        chk8("burst_step3", q, 8'h08);
        chk1("burst_done", done, 1'b1);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        chk_int("burst_busy_cycles", busy_cnt, 3);
        chk_int("burst_done_pulses", done_cnt, 1);

        // Burst paused for two cycles.
        cyc(0, 1, 3'd3, 0, 0, 8'h01, 0, 0);
        busy_cnt = 0; done_cnt = 0;
        cyc(0, 1, 3'd4, 0, 0, 8'h00, 1, 4'd3);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
        chk8("pause_hold", q, 8'h02);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        chk8("pause_final", q, 8'h08);
        chk_int("pause_busy_cycles", busy_cnt, 5);
        chk_int("pause_done_pulses", done_cnt, 1);

        // Rejected starts: zero length, then a non-shift mode.
        busy_cnt = 0; done_cnt = 0;
        cyc(0, 1, 3'd4, 0, 0, 8'h00, 1, 4'd0);
        chk8("len0_plain_rot", q, 8'h10);
        cyc(0, 1, 3'd3, 0, 0, 8'h3C, 1, 4'd5);
        chk8("load_start_plain", q, 8'h3C);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        chk_int("reject_busy_cycles", busy_cnt, 0);
        chk_int("reject_done_pulses", done_cnt, 0);

        // Reset on the second RUN cycle aborts the burst without done.
        busy_cnt = 0; done_cnt = 0;
        cyc(0, 1, 3'd4, 0, 0, 8'h00, 1, 4'd3);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        cyc(1, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        chk8("abort_q", q, 8'h00);
        chk1("abort_busy", busy, 1'b0);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        chk_int("abort_done_pulses", done_cnt, 0);

        // Back-to-back: new start in the done cycle is accepted at once.
        cyc(0, 1, 3'd3, 0, 0, 8'h01, 0, 0);
        cyc(0, 1, 3'd4, 0, 0, 8'h00, 1, 4'd2);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        chk1("b2b_first_done", done, 1'b1);
        cyc(0, 1, 3'd5, 0, 0, 8'h00, 1, 4'd1);
        chk1("b2b_accept_busy", busy, 1'b1);
        chk8("b2b_accept_hold", q, 8'h04);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);
        chk8("b2b_rotdn", q, 8'h02);
        chk1("b2b_second_done", done, 1'b1);
        cyc(0, 1, 3'd0, 0, 0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
